// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: latches a decoded memory op and runs one or two MFA/MOC RAM transfers.
module mem_access_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        L,
  input  logic        D,
  input  logic [1:0]  WB,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_lo,
  input  logic [31:0] wdata_hi,
  input  logic        MOC,
  input  logic [31:0] ram_rdata,
  output logic        MFA,
  output logic        RW,
  output logic [31:0] ram_addr,
  output logic [1:0]  ram_size,
  output logic [31:0] ram_wdata,
  output logic [31:0] rdata_lo,
  output logic [31:0] rdata_hi,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, REQ1, GAP, REQ2, DONE, ERR} state_t;
  state_t state, nxt;
  logic l_q, d_q, bad, req, tmo;
  logic [1:0] size_q;
  logic [31:0] addr_q, wlo_q, whi_q;
  logic [7:0] cnt;
  assign bad = D ? (addr[2:0] != 3'd0)
                 : (WB == 2'b11) || (WB == 2'b10 && addr[1:0] != 2'd0) || (WB == 2'b00 && addr[0]);
  assign req = state == REQ1 || state == REQ2;
  assign tmo = cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (bad ? ERR : REQ1) : IDLE;
      REQ1:    nxt = MOC ? (d_q ? GAP : DONE) : (tmo ? ERR : REQ1);
      GAP:     nxt = REQ2;
      REQ2:    nxt = MOC ? DONE : (tmo ? ERR : REQ2);
      default: nxt = IDLE;
    endcase
  end
  // counter only runs while a REQ state is held, so any state change clears it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      l_q <= 1'b0;
      d_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      wlo_q <= '0;
      whi_q <= '0;
      cnt <= '0;
      rdata_lo <= '0;
      rdata_hi <= '0;
    end else begin
      if (state == IDLE && start) begin
        l_q <= L;
        d_q <= D;
        size_q <= D ? 2'b10 : WB == 2'b10 ? 2'b10 : WB == 2'b01 ? 2'b00 : 2'b01;
        addr_q <= addr;
        wlo_q <= wdata_lo;
        whi_q <= wdata_hi;
      end
      cnt <= (req && nxt == state) ? cnt + 8'd1 : 8'd0;
      if (state == REQ1 && MOC && l_q) rdata_lo <= ram_rdata;
      if (state == REQ2 && MOC && l_q) rdata_hi <= ram_rdata;
    end
  assign MFA = req;
  assign RW = l_q;
  assign ram_addr = state == REQ2 ? addr_q + 32'd4 : addr_q;
  assign ram_size = size_q;
  assign ram_wdata = state == REQ2 ? whi_q : wlo_q;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign err = state == ERR;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed and randomized checks against a cycle-count/transfer-list model.
module tb_mem_access_sequencer;
  localparam int TO = 15;
  logic clk = 0, reset = 1, start = 0, L = 0, D = 0, MOC = 0;
  logic [1:0] WB = 0;
  logic [31:0] addr = 0, wdata_lo = 0, wdata_hi = 0, ram_rdata = 0;
  logic MFA, RW, busy, done, err;
  logic [1:0] ram_size;
  logic [31:0] ram_addr, ram_wdata, rdata_lo, rdata_hi;
  int checks = 0, errors = 0;
  int o_cyc, o_mfa, o_ntr;
  bit o_done, o_err, o_idle_ok;
  logic [31:0] tr_addr[2], tr_wdata[2];
  logic [1:0] tr_size[2];
  logic tr_rw[2];
  int e_cyc, e_mfa, e_ntr;
  bit e_err;
  logic [31:0] e_addr[2], e_wdata[2];
  logic [1:0] e_size[2];
  logic e_rw[2];
  logic [31:0] m_lo = 0, m_hi = 0;

  mem_access_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .L(L), .D(D), .WB(WB), .addr(addr),
    .wdata_lo(wdata_lo), .wdata_hi(wdata_hi), .MOC(MOC), .ram_rdata(ram_rdata),
    .MFA(MFA), .RW(RW), .ram_addr(ram_addr), .ram_size(ram_size), .ram_wdata(ram_wdata),
    .rdata_lo(rdata_lo), .rdata_hi(rdata_hi), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // Expected outcome from the access rules: a REQ half answered after dl waits takes dl+1 cycles,
  // a half whose wait reaches TO aborts after TO cycles; the gap adds one cycle.
  task automatic model_op(input logic l, input logic d, input logic [1:0] wb, input logic [31:0] a,
                          input logic [31:0] wlo, input logic [31:0] whi, input int dl1, input int dl2,
                          input logic [31:0] r1, input logic [31:0] r2);
    bit bad;
    int t, n, dl;
    bad = d ? (a[2:0] != 3'd0) : (wb == 2'b11 || (wb == 2'b10 && a[1:0] != 2'd0) || (wb == 2'b00 && a[0]));
    e_ntr = 0; e_mfa = 0; e_err = bad; e_cyc = 1;
    if (bad) return;
    n = d ? 2 : 1;
    t = 0;
    for (int i = 0; i < n; i++) begin
      dl = i == 0 ? dl1 : dl2;
      if (dl >= TO) begin
        e_err = 1; e_cyc = t + TO + 1; e_mfa += TO;
        return;
      end
      t += dl + 1; e_mfa += dl + 1;
      e_addr[i] = a + 32'(4 * i);
      e_size[i] = d ? 2'b10 : (wb == 2'b10 ? 2'b10 : wb == 2'b01 ? 2'b00 : 2'b01);
      e_wdata[i] = i == 0 ? wlo : whi;
      e_rw[i] = l;
      e_ntr++;
      if (l && i == 0) m_lo = r1;
      if (l && i == 1) m_hi = r2;
      if (i == 0 && d) t++;
    end
    e_cyc = t + 1;
  endtask

  // Issues one start and plays the RAM: MOC answers after dl waits, random MOC noise while MFA is low.
  task automatic drive_op(input logic l, input logic d, input logic [1:0] wb, input logic [31:0] a,
                          input logic [31:0] wlo, input logic [31:0] whi, input int dl1, input int dl2,
                          input logic [31:0] r1, input logic [31:0] r2, input bit repulse);
    int h;
    @(negedge clk);
    L = l; D = d; WB = wb; addr = a; wdata_lo = wlo; wdata_hi = whi; start = 1; MOC = 0;
    o_cyc = 0; o_done = 0; o_err = 0; o_mfa = 0; o_ntr = 0; h = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = repulse;
      if (repulse) begin addr = 32'h5555_5550; D = ~d; end
      if (done || err) begin
        o_cyc = c; o_done = done; o_err = err;
        break;
      end
      MOC = 0;
      ram_rdata = $urandom;
      if (MFA) begin
        o_mfa++;
        if (h >= (o_ntr == 0 ? dl1 : dl2)) begin
          MOC = 1;
          ram_rdata = o_ntr == 0 ? r1 : r2;
          if (o_ntr < 2) begin
            tr_addr[o_ntr] = ram_addr; tr_size[o_ntr] = ram_size;
            tr_wdata[o_ntr] = ram_wdata; tr_rw[o_ntr] = RW;
          end
          o_ntr++; h = 0;
        end else h++;
      end else MOC = 1'($urandom_range(0, 1));
    end
    if (o_cyc == 0) $display("FAIL op_bound: no done/err within 400 cycles");
    @(negedge clk);
    start = 0; MOC = 0;
    o_idle_ok = !busy && !done && !err && !MFA;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({MFA, RW, ram_addr, ram_size, ram_wdata, rdata_lo, rdata_hi, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_async: MFA=%b RW=%b addr=%h size=%b wdata=%h lo=%h hi=%h busy=%b done=%b err=%b want all 0",
               MFA, RW, ram_addr, ram_size, ram_wdata, rdata_lo, rdata_hi, busy, done, err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || MFA !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b MFA=%b want 0 0", busy, MFA);
    end
  endtask

  task automatic test_word_load;
    model_op(1, 0, 2'b10, 32'h100, 0, 0, 0, 255, 32'hDEADBEEF, 0);
    drive_op(1, 0, 2'b10, 32'h100, 0, 0, 0, 255, 32'hDEADBEEF, 0, 0);
    checks++;
    if (!(o_done && !o_err && o_cyc == 2)) begin
      errors++;
      $display("FAIL word_done: done=%0b err=%0b cycle=%0d want 1 0 2", o_done, o_err, o_cyc);
    end
    checks++;
    if (o_mfa != 1 || o_ntr != 1) begin
      errors++;
      $display("FAIL word_mfa: mfa_cycles=%0d transfers=%0d want 1 1", o_mfa, o_ntr);
    end
    checks++;
    if ({tr_rw[0], tr_size[0], tr_addr[0]} !== {1'b1, 2'b10, 32'h100}) begin
      errors++;
      $display("FAIL word_xfer: rw=%b size=%b addr=%h want 1 10 00000100", tr_rw[0], tr_size[0], tr_addr[0]);
    end
    checks++;
    if (rdata_lo !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_rdata: rdata_lo=%h want deadbeef", rdata_lo);
    end
  endtask

  task automatic test_dword_store;
    model_op(0, 1, 2'b00, 32'h208, 32'h11111111, 32'h22222222, 2, 2, 32'h99999999, 32'h99999999);
    drive_op(0, 1, 2'b00, 32'h208, 32'h11111111, 32'h22222222, 2, 2, 32'h99999999, 32'h99999999, 0);
    checks++;
    if (!(o_done && !o_err && o_cyc == 8 && o_mfa == 6 && o_ntr == 2)) begin
      errors++;
      $display("FAIL dword_timing: done=%0b err=%0b cycle=%0d mfa=%0d xfers=%0d want 1 0 8 6 2",
               o_done, o_err, o_cyc, o_mfa, o_ntr);
    end
    checks++;
    if ({tr_rw[0], tr_size[0], tr_addr[0], tr_wdata[0]} !== {1'b0, 2'b10, 32'h208, 32'h11111111}) begin
      errors++;
      $display("FAIL dword_xfer0: rw=%b size=%b addr=%h data=%h want 0 10 00000208 11111111",
               tr_rw[0], tr_size[0], tr_addr[0], tr_wdata[0]);
    end
    checks++;
    if ({tr_rw[1], tr_size[1], tr_addr[1], tr_wdata[1]} !== {1'b0, 2'b10, 32'h20C, 32'h22222222}) begin
      errors++;
      $display("FAIL dword_xfer1: rw=%b size=%b addr=%h data=%h want 0 10 0000020c 22222222",
               tr_rw[1], tr_size[1], tr_addr[1], tr_wdata[1]);
    end
    checks++;
    if (rdata_lo !== 32'hDEADBEEF || rdata_hi !== 32'h0) begin
      errors++;
      $display("FAIL dword_rdata_kept: lo=%h hi=%h want deadbeef 00000000", rdata_lo, rdata_hi);
    end
  endtask

  task automatic test_misalign;
    logic [1:0] wbs[4] = '{2'b10, 2'b00, 2'b10, 2'b11};
    logic ds[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] as[4] = '{32'h102, 32'h101, 32'h204, 32'h100};
    for (int k = 0; k < 4; k++) begin
      model_op(1, ds[k], wbs[k], as[k], 0, 0, 0, 0, 32'h77777777, 32'h77777777);
      drive_op(1, ds[k], wbs[k], as[k], 0, 0, 0, 0, 32'h77777777, 32'h77777777, 0);
      checks++;
      if (!(o_err && !o_done && o_cyc == 1 && o_mfa == 0 && o_idle_ok)) begin
        errors++;
        $display("FAIL misalign%0d: err=%0b done=%0b cycle=%0d mfa=%0d idle=%0b want 1 0 1 0 1",
                 k, o_err, o_done, o_cyc, o_mfa, o_idle_ok);
      end
    end
    checks++;
    if (rdata_lo !== 32'hDEADBEEF || rdata_hi !== 32'h0) begin
      errors++;
      $display("FAIL misalign_rdata: lo=%h hi=%h want deadbeef 00000000", rdata_lo, rdata_hi);
    end
  endtask

  task automatic test_timeout;
    model_op(1, 0, 2'b10, 32'h400, 0, 0, 255, 255, 0, 0);
    drive_op(1, 0, 2'b10, 32'h400, 0, 0, 255, 255, 0, 0, 0);
    checks++;
    if (!(o_err && !o_done && o_cyc == TO + 1 && o_mfa == TO && o_ntr == 0 && o_idle_ok)) begin
      errors++;
      $display("FAIL timeout: err=%0b done=%0b cycle=%0d mfa=%0d xfers=%0d idle=%0b want 1 0 %0d %0d 0 1",
               o_err, o_done, o_cyc, o_mfa, o_ntr, o_idle_ok, TO + 1, TO);
    end
    model_op(1, 0, 2'b10, 32'h404, 0, 0, 0, 0, 32'hCAFEF00D, 0);
    drive_op(1, 0, 2'b10, 32'h404, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0);
    checks++;
    if (!(o_done && !o_err && o_cyc == 2 && rdata_lo === 32'hCAFEF00D)) begin
      errors++;
      $display("FAIL after_timeout: done=%0b err=%0b cycle=%0d lo=%h want 1 0 2 cafef00d",
               o_done, o_err, o_cyc, rdata_lo);
    end
  endtask

  task automatic test_byte_ignore_start;
    model_op(1, 0, 2'b01, 32'h103, 0, 0, 1, 0, 32'h000000A5, 0);
    drive_op(1, 0, 2'b01, 32'h103, 0, 0, 1, 0, 32'h000000A5, 0, 1);
    checks++;
    if (!(o_done && !o_err && o_cyc == 3 && o_ntr == 1 && o_idle_ok)) begin
      errors++;
      $display("FAIL byte_ctrl: done=%0b err=%0b cycle=%0d xfers=%0d idle=%0b want 1 0 3 1 1",
               o_done, o_err, o_cyc, o_ntr, o_idle_ok);
    end
    checks++;
    if ({tr_size[0], tr_addr[0], rdata_lo} !== {2'b00, 32'h103, 32'h000000A5}) begin
      errors++;
      $display("FAIL byte_xfer: size=%b addr=%h lo=%h want 00 00000103 000000a5", tr_size[0], tr_addr[0], rdata_lo);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    L = 1; D = 1; WB = 2'b10; addr = 32'h300; start = 1; MOC = 0;
    @(negedge clk);
    start = 0; MOC = 1; ram_rdata = 32'hAAAA5555;
    @(negedge clk);
    MOC = 0;
    @(negedge clk);
    checks++;
    if (MFA !== 1'b1 || ram_addr !== 32'h304) begin
      errors++;
      $display("FAIL mid_req2: MFA=%b addr=%h want 1 00000304", MFA, ram_addr);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({MFA, RW, ram_addr, ram_size, ram_wdata, rdata_lo, rdata_hi, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: MFA=%b RW=%b addr=%h size=%b wdata=%h lo=%h hi=%h busy=%b done=%b err=%b want all 0",
               MFA, RW, ram_addr, ram_size, ram_wdata, rdata_lo, rdata_hi, busy, done, err);
    end
    #1 reset = 0;
    m_lo = 0; m_hi = 0;
    model_op(1, 0, 2'b10, 32'h500, 0, 0, 0, 0, 32'h13572468, 0);
    drive_op(1, 0, 2'b10, 32'h500, 0, 0, 0, 0, 32'h13572468, 0, 0);
    checks++;
    if (!(o_done && o_cyc == 2 && rdata_lo === 32'h13572468 && rdata_hi === 32'h0)) begin
      errors++;
      $display("FAIL after_reset: done=%0b cycle=%0d lo=%h hi=%h want 1 2 13572468 00000000",
               o_done, o_cyc, rdata_lo, rdata_hi);
    end
  endtask

  task automatic test_random;
    logic l, d;
    logic [1:0] wb;
    logic [31:0] a, wlo, whi, r1, r2;
    int dl[2], r;
    for (int k = 0; k < 60; k++) begin
      l = 1'($urandom); d = 1'($urandom); wb = 2'($urandom);
      a = $urandom & 32'hFFFF_FFF8;
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'($urandom);
      if ($urandom_range(0, 7) == 0) a[31:3] = '1;
      wlo = $urandom; whi = $urandom; r1 = $urandom; r2 = $urandom;
      for (int i = 0; i < 2; i++) begin
        r = $urandom_range(0, 15);
        dl[i] = r < 10 ? r % 4 : r < 12 ? TO - 1 : r < 14 ? TO : 255;
      end
      model_op(l, d, wb, a, wlo, whi, dl[0], dl[1], r1, r2);
      drive_op(l, d, wb, a, wlo, whi, dl[0], dl[1], r1, r2, 0);
      checks++;
      if (o_err != e_err || o_done == e_err || o_cyc != e_cyc) begin
        errors++;
        $display("FAIL rand%0d_status: done=%0b err=%0b cycle=%0d want err=%0b cycle=%0d",
                 k, o_done, o_err, o_cyc, e_err, e_cyc);
      end
      checks++;
      if (o_mfa != e_mfa || o_ntr != e_ntr || !o_idle_ok) begin
        errors++;
        $display("FAIL rand%0d_mfa: mfa=%0d xfers=%0d idle=%0b want %0d %0d 1", k, o_mfa, o_ntr, o_idle_ok, e_mfa, e_ntr);
      end
      for (int i = 0; i < e_ntr && i < o_ntr; i++) begin
        checks++;
        if ({tr_rw[i], tr_size[i], tr_addr[i], tr_wdata[i]} !== {e_rw[i], e_size[i], e_addr[i], e_wdata[i]}) begin
          errors++;
          $display("FAIL rand%0d_xfer%0d: rw=%b size=%b addr=%h data=%h want %b %b %h %h", k, i,
                   tr_rw[i], tr_size[i], tr_addr[i], tr_wdata[i], e_rw[i], e_size[i], e_addr[i], e_wdata[i]);
        end
      end
      checks++;
      if (rdata_lo !== m_lo || rdata_hi !== m_hi) begin
        errors++;
        $display("FAIL rand%0d_rdata: lo=%h hi=%h want %h %h", k, rdata_lo, rdata_hi, m_lo, m_hi);
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_dword_store;
    test_misalign;
    test_timeout;
    test_byte_ignore_start;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Multi-cycle sequencer between the memory-operation decoder and the RAM port. On a start pulse from the control unit it latches the decoded access attributes (L, D, WB), the effective address and the store data. It then runs one RAM transaction, or two for doublewords, using the MFA/MOC handshake, and reports done, or err on misalignment, illegal size or timeout. It sits between the control unit's MAR/MDR datapath and the RAM.

## Interface
Parameters:
- TIMEOUT, 15: cycles MFA may be held without MOC before aborting; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- start  in  1  request pulse; sampled only in IDLE.
- L  in  1  1 = load, 0 = store.
- D  in  1  1 = doubleword, i.e. two word transfers at addr and addr+4.
- WB  in  2  size code when D=0: 10 word, 01 byte, 00 halfword, 11 illegal.
- addr  in  32  effective address.
- wdata_lo  in  32  store data for the first or only transfer.
- wdata_hi  in  32  store data for the second doubleword transfer.
- MOC  in  1  RAM memory-operation-complete.
- ram_rdata  in  32  RAM read data, valid when MOC=1.
- MFA  out  1  RAM memory-function-activate.
- RW  out  1  1 = read, 0 = write; equals latched L.
- ram_addr  out  32  transfer address.
- ram_size  out  2  00 byte, 01 halfword, 10 word.
- ram_wdata  out  32  transfer write data.
- rdata_lo  out  32  first or only loaded word.
- rdata_hi  out  32  second loaded word (doubleword only).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle abort pulse.

## Operation
- States: IDLE, REQ1, GAP, REQ2, DONE, ERR. Outputs depend on the state register and latched registers only. No combinational path from any input to any output.
- IDLE, start=1:
  - Latch L, D, WB, addr, wdata_lo, wdata_hi.
  - Misaligned or illegal access goes to ERR. Misaligned means: D=1 with addr[2:0]≠0; word with addr[1:0]≠0; halfword with addr[0]≠0. Illegal means D=0 with WB=11.
  - Otherwise go to REQ1.
- start is ignored outside IDLE.
- REQ1:
  - MFA=1, ram_addr=addr, ram_wdata=wdata_lo.
  - ram_size is 10 if D=1, otherwise mapped from WB.
  - On MOC=1: when L=1, capture ram_rdata into rdata_lo. Then go to GAP if D=1, else DONE.
- GAP: MFA=0 for exactly one cycle, then REQ2.
- REQ2:
  - MFA=1, ram_addr=addr+4 (32-bit wrap: 0xFFFFFFF8+4=0xFFFFFFFC), ram_wdata=wdata_hi, ram_size=10.
  - On MOC=1: when L=1, capture rdata_hi. Go to DONE.
- Timeout counter:
  - Cleared on entering REQ1 or REQ2; increments each REQ cycle with MOC=0.
  - When it reaches TIMEOUT with MOC still 0, go to ERR.
  - MOC=1 in the same cycle the count reaches TIMEOUT wins: the transfer completes.
- DONE: done=1, MFA=0, then IDLE.
- ERR: err=1, MFA=0, then IDLE. rdata registers keep any word already captured; no further transfer is issued.
- Stores never modify rdata_lo or rdata_hi.
- MOC outside REQ1/REQ2 is ignored.

## Timing
- Reset values: state IDLE, MFA=0, RW=0, ram_addr=0, ram_size=00, ram_wdata=0, rdata_lo=0, rdata_hi=0, busy=0, done=0, err=0, counter=0.
- Reset asserted mid-transfer forces MFA=0 immediately (asynchronous) and discards the transaction.
- Single access, MOC on the first REQ1 cycle: start sampled at edge 0, REQ1 in cycle 1, DONE in cycle 2, IDLE in cycle 3. Minimum latency from start to done is 2 cycles.
- Doubleword, MOC immediate: REQ1 in cycle 1, GAP in 2, REQ2 in 3, DONE in 4.
- Each cycle of MOC delay adds one cycle.
- Earliest next start is accepted in the cycle after DONE or ERR, i.e. when back in IDLE.
- Error on start: ERR in cycle 1, IDLE in cycle 2, and MFA never rises.
- Timeout: ERR is entered TIMEOUT cycles after the REQ entry edge.

## Test plan
- Word load at addr=0x100, MOC high in first REQ1 cycle, ram_rdata=0xDEADBEEF -> MFA high exactly 1 cycle, RW=1, ram_size=10, rdata_lo=0xDEADBEEF, done pulses in cycle 2.
- Doubleword store at addr=0x208, wdata_lo=0x11111111, wdata_hi=0x22222222, MOC delayed 2 cycles per half -> first transfer writes 0x11111111 to 0x208, MFA low for one GAP cycle, second transfer writes 0x22222222 to 0x20C, done in cycle 8, rdata registers unchanged.
- Misalignment: word at 0x102, halfword at 0x101, doubleword at 0x204, and D=0/WB=11 -> err pulse in cycle 1, MFA never asserted, done never asserted.
- Timeout with TIMEOUT=15 and MOC held 0 -> MFA high 15 cycles, err pulse, IDLE; a following word load completes normally.
- Byte load at 0x103, WB=01 -> no error, ram_size=00; start re-pulsed while busy -> ignored, exactly one transaction.
- Reset asserted during doubleword REQ2 -> MFA and busy fall without a clock edge, all outputs at reset values, next start behaves as from power-up.
